// File: rtl/lcd_pkg.sv
// Shared constants, timing defaults and FSM encodings for the HD44780 read engine.
package lcd_pkg;

    localparam logic       OP_RD_BF      = 1'b0;
    localparam logic       OP_RD_DDRAM   = 1'b1;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // Defaults for a 50 MHz clock
    localparam int unsigned T_AS_DEF     = 3;
    localparam int unsigned T_EH_DEF     = 25;
    localparam int unsigned T_AH_DEF     = 2;
    localparam int unsigned T_EL_DEF     = 25;
    localparam int unsigned POLL_MAX_DEF = 2000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_RD_BF,
        ST_POLL1,
        ST_SETADDR,
        ST_POLL2,
        ST_RDATA,
        ST_FINISH
    } rd_state_t;

    typedef enum logic [2:0] {
        BC_IDLE,
        BC_SETUP,
        BC_EHIGH,
        BC_HOLD,
        BC_RECOV
    } bc_state_t;

endpackage

// File: rtl/lcd_bus_cycle.sv
// Single HD44780 bus access: SETUP, EHIGH, HOLD, RECOV. A start in the last
// RECOV cycle chains the next access with no idle gap.
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS = T_AS_DEF,
    parameter int unsigned T_EH = T_EH_DEF,
    parameter int unsigned T_AH = T_AH_DEF,
    parameter int unsigned T_EL = T_EL_DEF
) (
    input  logic       clk,
    input  logic       s_rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       cycle_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data_o,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_i
);

    bc_state_t   phase;
    logic [15:0] cnt;

    assign cycle_done = (phase == BC_RECOV) && (cnt == 16'(T_EL - 1));

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            phase       <= BC_IDLE;
            cnt         <= '0;
            rdata       <= '0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_data_o  <= '0;
            lcd_data_oe <= 1'b0;
        end else if (start && (phase == BC_IDLE || cycle_done)) begin
            phase       <= BC_SETUP;
            cnt         <= '0;
            lcd_rs      <= rs;
            lcd_rw      <= rw;
            lcd_en      <= 1'b0;
            lcd_data_o  <= rw ? 8'h00 : wdata;
            lcd_data_oe <= ~rw;
        end else begin
            unique case (phase)
                BC_SETUP: begin
                    if (cnt == 16'(T_AS - 1)) begin
                        phase  <= BC_EHIGH;
                        cnt    <= '0;
                        lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BC_EHIGH: begin
                    if (cnt == 16'(T_EH - 1)) begin
                        phase  <= BC_HOLD;
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                        if (lcd_rw) rdata <= lcd_data_i;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BC_HOLD: begin
                    if (cnt == 16'(T_AH - 1)) begin
                        phase       <= BC_RECOV;
                        cnt         <= '0;
                        lcd_data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BC_RECOV: begin
                    if (cycle_done) begin
                        phase      <= BC_IDLE;
                        cnt        <= '0;
                        lcd_rs     <= 1'b0;
                        lcd_rw     <= 1'b0;
                        lcd_data_o <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/lcd_reader.sv
// LCD read engine: BF/AC read or DDRAM read-back (poll, set address, poll, read)
// sequenced over lcd_bus_cycle while holding the shared bus via bus_req/bus_gnt.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS     = T_AS_DEF,
    parameter int unsigned T_EH     = T_EH_DEF,
    parameter int unsigned T_AH     = T_AH_DEF,
    parameter int unsigned T_EL     = T_EL_DEF,
    parameter int unsigned POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       s_rst_n,
    input  logic       req,
    input  logic       op,
    input  logic [6:0] addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       timeout_err,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data_o,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_i
);

    rd_state_t   state, nxt;
    logic        op_q, launch, start, finish, tmo, cycle_done, poll_last;
    logic        acc_rs, acc_rw;
    logic [6:0]  addr_q;
    logic [7:0]  acc_wdata, bc_rdata;
    logic [15:0] poll_cnt;

    assign poll_last = (poll_cnt == 16'(POLL_MAX - 1));

    // Next access is decided in the last RECOV cycle so accesses run back-to-back.
    always_comb begin
        nxt    = state;
        start  = launch;
        finish = 1'b0;
        tmo    = 1'b0;
        if (cycle_done) begin
            unique case (state)
                ST_POLL1, ST_POLL2: begin
                    if (!bc_rdata[7]) begin
                        nxt   = (state == ST_POLL1) ? ST_SETADDR : ST_RDATA;
                        start = 1'b1;
                    end else if (poll_last) begin
                        finish = 1'b1;
                        tmo    = 1'b1;
                    end else begin
                        start = 1'b1;
                    end
                end
                ST_SETADDR: begin
                    nxt   = ST_POLL2;
                    start = 1'b1;
                end
                ST_RD_BF, ST_RDATA: finish = 1'b1;
                default: ;
            endcase
        end
        acc_rs    = (nxt == ST_RDATA);
        acc_rw    = (nxt != ST_SETADDR);
        acc_wdata = CMD_SET_DDRAM | {1'b0, addr_q};
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_RD_BF;
            addr_q      <= '0;
            launch      <= 1'b0;
            poll_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
            bus_req     <= 1'b0;
        end else begin
            done   <= 1'b0;
            launch <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_q        <= op;
                        addr_q      <= addr;
                        busy        <= 1'b1;
                        bus_req     <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (bus_gnt) begin
                        launch   <= 1'b1;
                        poll_cnt <= '0;
                        state    <= (op_q == OP_RD_DDRAM) ? ST_POLL1 : ST_RD_BF;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default: begin
                    if (finish) begin
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        bus_req     <= 1'b0;
                        timeout_err <= tmo;
                        rd_data     <= tmo ? 8'hFF : bc_rdata;
                        state       <= ST_FINISH;
                    end else begin
                        state <= nxt;
                        if (cycle_done) poll_cnt <= (nxt == state) ? poll_cnt + 16'd1 : '0;
                    end
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .T_AS(T_AS),
        .T_EH(T_EH),
        .T_AH(T_AH),
        .T_EL(T_EL)
    ) u_bus_cycle (
        .clk        (clk),
        .s_rst_n    (s_rst_n),
        .start      (start),
        .rs         (acc_rs),
        .rw         (acc_rw),
        .wdata      (acc_wdata),
        .rdata      (bc_rdata),
        .cycle_done (cycle_done),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data_o (lcd_data_o),
        .lcd_data_oe(lcd_data_oe),
        .lcd_data_i (lcd_data_i)
    );

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader with a small HD44780 read model and bus monitor.
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       req = 1'b0;
    logic       op = 1'b0;
    logic [6:0] addr = '0;
    logic       bus_gnt = 1'b1;
    logic       busy, done, timeout_err, bus_req;
    logic [7:0] rd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_data_oe;
    logic [7:0] lcd_data_o, lcd_data_i;

    // LCD model: BF is 1 for the first bf_polls status reads after rd0_base, or always if stuck
    logic       bf_stuck = 1'b0;
    int         bf_polls = 0;
    int         rd0_base = 0;
    logic [6:0] ac_val = '0;
    logic [7:0] dd_byte = '0;
    logic       bf;

    int acc_cnt = 0, rd0_cnt = 0, rs1_cnt = 0, wr_cnt = 0, oe_bad = 0, done_cnt = 0;
    int en_len = 0, last_en_len = 0;
    logic [7:0] wr_data = '0;
    logic       wr_rs = 1'b0;
    logic       en_q = 1'b0;

    int checks = 0, passed = 0;
    int lat, n;
    int acc_b, wr_b, rs1_b, done_b;

    assign bf = bf_stuck || ((rd0_cnt - rd0_base) <= bf_polls);
    assign lcd_data_i = lcd_rs ? dd_byte : {bf, ac_val};

    always #5 clk = ~clk;

    lcd_reader #(
        .POLL_MAX(4)
    ) dut (
        .clk        (clk),
        .s_rst_n    (s_rst_n),
        .req        (req),
        .op         (op),
        .addr       (addr),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .timeout_err(timeout_err),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data_o (lcd_data_o),
        .lcd_data_oe(lcd_data_oe),
        .lcd_data_i (lcd_data_i)
    );

    always @(negedge clk) begin
        if (lcd_en && !en_q) begin
            acc_cnt++;
            en_len = 0;
            if (!lcd_rs && lcd_rw) rd0_cnt++;
            if (lcd_rs && lcd_rw) rs1_cnt++;
            if (lcd_data_oe && !lcd_rw) begin
                wr_cnt++;
                wr_data = lcd_data_o;
                wr_rs   = lcd_rs;
            end
        end
        if (lcd_en) en_len++;
        if (!lcd_en && en_q) last_en_len = en_len;
        if (lcd_data_oe && lcd_rw) oe_bad++;
        if (done) done_cnt++;
        en_q = lcd_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic snap();
        rd0_base = rd0_cnt;
        acc_b    = acc_cnt;
        wr_b     = wr_cnt;
        rs1_b    = rs1_cnt;
        done_b   = done_cnt;
    endtask

    // Issue a request, measure edges from the sampling edge to done, then
    // present a req in the done cycle which must be ignored.
    task automatic run_op(input logic o, input logic [6:0] a, output int l);
        @(negedge clk);
        op = o; addr = a; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        l = 0;
        while (done !== 1'b1 && l < 3000) begin
            @(posedge clk); #1;
            l++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("req_in_finish_ignored", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1;
        chk("reset_outputs",
            {8'd0, busy, done, timeout_err, bus_req, lcd_rs, lcd_rw, lcd_en, lcd_data_oe, lcd_data_o, rd_data},
            32'd0);
        repeat (3) @(negedge clk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: BF/AC read
        ac_val = 7'h45; bf_polls = 0; snap();
        run_op(1'b0, 7'h00, lat);
        chk("t1_latency", lat, 57);
        chk("t1_rd_data", {24'd0, rd_data}, 32'h45);
        chk("t1_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("t1_en_high_len", last_en_len, 25);
        chk("t1_oe_during_read", oe_bad, 0);
        chk("t1_status_reads", rd0_cnt - rd0_base, 1);
        chk("t1_accesses", acc_cnt - acc_b, 1);

        // 2: DDRAM read at 0x40, BF clear
        dd_byte = 8'h31; snap();
        run_op(1'b1, 7'h40, lat);
        chk("t2_latency", lat, 222);
        chk("t2_rd_data", {24'd0, rd_data}, 32'h31);
        chk("t2_writes", wr_cnt - wr_b, 1);
        chk("t2_wr_data", {24'd0, wr_data}, 32'hC0);
        chk("t2_wr_rs", {31'd0, wr_rs}, 32'd0);
        chk("t2_rs1_reads", rs1_cnt - rs1_b, 1);
        chk("t2_accesses", acc_cnt - acc_b, 4);
        chk("t2_oe_during_read", oe_bad, 0);

        // 3: BF busy for three polls in POLL1
        dd_byte = 8'h5A; bf_polls = 3; snap();
        run_op(1'b1, 7'h05, lat);
        chk("t3_latency", lat, 387);
        chk("t3_rd_data", {24'd0, rd_data}, 32'h5A);
        chk("t3_wr_data", {24'd0, wr_data}, 32'h85);
        chk("t3_accesses", acc_cnt - acc_b, 7);

        // 4: BF stuck, POLL_MAX=4
        bf_stuck = 1'b1; bf_polls = 0; snap();
        run_op(1'b1, 7'h12, lat);
        chk("t4_latency", lat, 222);
        chk("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
        chk("t4_rd_data", {24'd0, rd_data}, 32'hFF);
        chk("t4_writes", wr_cnt - wr_b, 0);
        chk("t4_polls", rd0_cnt - rd0_base, 4);
        bf_stuck = 1'b0;

        // 5: grant withheld for 100 clocks, second req while busy
        bus_gnt = 1'b0; ac_val = 7'h22; snap();
        @(negedge clk);
        op = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("t5_timeout_cleared", {31'd0, timeout_err}, 32'd0);
        chk("t5_busy_bus_req", {30'd0, busy, bus_req}, 32'd3);
        repeat (50) @(posedge clk);
        @(negedge clk);
        op = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (48) @(posedge clk);
        @(negedge clk);
        chk("t5_no_access_without_gnt", acc_cnt - acc_b, 0);
        chk("t5_bus_req_waiting", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        chk("t5_rw_before_setup", {31'd0, lcd_rw}, 32'd0);
        @(posedge clk); #1;
        chk("t5_rw_at_setup", {31'd0, lcd_rw}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_done_seen", {31'd0, done}, 32'd1);
        chk("t5_rd_data", {24'd0, rd_data}, 32'h22);
        chk("t5_accesses", acc_cnt - acc_b, 1);
        @(posedge clk); #1;
        chk("t5_single_done", done_cnt - done_b, 1);

        // 6: reset during EHIGH of the DDRAM data read
        dd_byte = 8'h77; snap();
        @(negedge clk);
        op = 1'b1; addr = 7'h10; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!(lcd_rs === 1'b1 && lcd_en === 1'b1) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_reached_rdata_ehigh", {31'd0, lcd_rs & lcd_en}, 32'd1);
        repeat (5) @(posedge clk);
        #2 s_rst_n = 1'b0;
        #1;
        chk("t6_async_reset_outputs",
            {25'd0, lcd_en, lcd_data_oe, busy, bus_req, done, lcd_rs, lcd_rw}, 32'd0);
        repeat (3) @(negedge clk);
        s_rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("t6_no_done_after_reset", done_cnt - done_b, 0);
        ac_val = 7'h33; snap();
        run_op(1'b0, 7'h00, lat);
        chk("t6_recovery_latency", lat, 57);
        chk("t6_recovery_rd_data", {24'd0, rd_data}, 32'h33);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
